// File: rtl/pipe_idex_if.sv
// Signal bundle between the ID stage and the ID/EX register: decoded ID fields in,
// registered IDEX copies plus hazard controls out.
interface pipe_idex_if #(
  parameter int DW      = 32,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
);
  logic [4:0]         IFIDRs;
  logic [4:0]         IFIDRt;
  logic [4:0]         IFIDRd;
  logic               ID_RegWr;
  logic               ID_MemRd;
  logic               ID_MemWr;
  logic [1:0]         ID_MemToReg;
  logic [1:0]         ID_RegDst;
  logic               ID_ALUSrc;
  logic [ALUOP_W-1:0] ID_ALUOp;
  logic [DW-1:0]      ID_BusA;
  logic [DW-1:0]      ID_BusB;
  logic [DW-1:0]      ID_Imm;
  logic [DW-1:0]      ID_PCPlus4;
  logic               Flush;

  logic [4:0]         IDEXRs;
  logic [4:0]         IDEXRt;
  logic [4:0]         IDEXRd;
  logic               IDEXRegWr;
  logic               IDEXMemRd;
  logic               IDEXMemWr;
  logic [1:0]         IDEXMemToReg;
  logic [1:0]         IDEXRegDst;
  logic               IDEXALUSrc;
  logic [ALUOP_W-1:0] IDEXALUOp;
  logic [DW-1:0]      IDEXBusA;
  logic [DW-1:0]      IDEXBusB;
  logic [DW-1:0]      IDEXImm;
  logic [DW-1:0]      IDEXPCPlus4;
  logic               Stall;
  logic               PCWr;
  logic               IFIDWr;
  logic [CNT_W-1:0]   BubbleCnt;

  // Flow control: no valid/ready pair here. ID presents a new instruction every cycle;
  // PCWr/IFIDWr low (Stall high) means "hold ID contents, this cycle's capture is a bubble".
  modport master (
    output IFIDRs, IFIDRt, IFIDRd, ID_RegWr, ID_MemRd, ID_MemWr, ID_MemToReg, ID_RegDst,
           ID_ALUSrc, ID_ALUOp, ID_BusA, ID_BusB, ID_Imm, ID_PCPlus4, Flush,
    input  IDEXRs, IDEXRt, IDEXRd, IDEXRegWr, IDEXMemRd, IDEXMemWr, IDEXMemToReg, IDEXRegDst,
           IDEXALUSrc, IDEXALUOp, IDEXBusA, IDEXBusB, IDEXImm, IDEXPCPlus4,
           Stall, PCWr, IFIDWr, BubbleCnt
  );

  modport slave (
    input  IFIDRs, IFIDRt, IFIDRd, ID_RegWr, ID_MemRd, ID_MemWr, ID_MemToReg, ID_RegDst,
           ID_ALUSrc, ID_ALUOp, ID_BusA, ID_BusB, ID_Imm, ID_PCPlus4, Flush,
    output IDEXRs, IDEXRt, IDEXRd, IDEXRegWr, IDEXMemRd, IDEXMemWr, IDEXMemToReg, IDEXRegDst,
           IDEXALUSrc, IDEXALUOp, IDEXBusA, IDEXBusB, IDEXImm, IDEXPCPlus4,
           Stall, PCWr, IFIDWr, BubbleCnt
  );
endinterface

// File: rtl/pipe_idex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// stall or flush, and a saturating bubble counter.
module pipe_idex_stage #(
  parameter int DW      = 32,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input logic         clk,
  input logic         reset,
  pipe_idex_if.slave  io
);
  logic [4:0]         rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic               regwr_q, regwr_d, memrd_q, memrd_d, memwr_q, memwr_d;
  logic [1:0]         memtoreg_q, memtoreg_d, regdst_q, regdst_d;
  logic               alusrc_q, alusrc_d;
  logic [ALUOP_W-1:0] aluop_q, aluop_d;
  logic [DW-1:0]      busa_q, busa_d, busb_q, busb_d, imm_q, imm_d, pc4_q, pc4_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               stall, bubble;

  // A load in EX whose destination (other than $0) is read by the instruction in ID.
  assign stall  = memrd_q & (|rt_q) & ((rt_q == io.IFIDRs) | (rt_q == io.IFIDRt));
  assign bubble = io.Flush | stall;

  always_comb begin
    rs_d       = io.IFIDRs;
    rt_d       = io.IFIDRt;
    rd_d       = io.IFIDRd;
    regwr_d    = io.ID_RegWr;
    memrd_d    = io.ID_MemRd;
    memwr_d    = io.ID_MemWr;
    memtoreg_d = io.ID_MemToReg;
    regdst_d   = io.ID_RegDst;
    alusrc_d   = io.ID_ALUSrc;
    aluop_d    = io.ID_ALUOp;
    busa_d     = io.ID_BusA;
    busb_d     = io.ID_BusB;
    imm_d      = io.ID_Imm;
    pc4_d      = io.ID_PCPlus4;
    cnt_d      = cnt_q;
    if (bubble) begin
      // Zeroed register numbers keep the bubble invisible to the forwarding unit.
      rs_d       = '0;
      rt_d       = '0;
      rd_d       = '0;
      regwr_d    = 1'b0;
      memrd_d    = 1'b0;
      memwr_d    = 1'b0;
      memtoreg_d = '0;
      regdst_d   = '0;
      alusrc_d   = 1'b0;
      aluop_d    = '0;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      regwr_q    <= 1'b0;
      memrd_q    <= 1'b0;
      memwr_q    <= 1'b0;
      memtoreg_q <= '0;
      regdst_q   <= '0;
      alusrc_q   <= 1'b0;
      aluop_q    <= '0;
      busa_q     <= '0;
      busb_q     <= '0;
      imm_q      <= '0;
      pc4_q      <= '0;
      cnt_q      <= '0;
    end else begin
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      regwr_q    <= regwr_d;
      memrd_q    <= memrd_d;
      memwr_q    <= memwr_d;
      memtoreg_q <= memtoreg_d;
      regdst_q   <= regdst_d;
      alusrc_q   <= alusrc_d;
      aluop_q    <= aluop_d;
      busa_q     <= busa_d;
      busb_q     <= busb_d;
      imm_q      <= imm_d;
      pc4_q      <= pc4_d;
      cnt_q      <= cnt_d;
    end
  end

  assign io.IDEXRs       = rs_q;
  assign io.IDEXRt       = rt_q;
  assign io.IDEXRd       = rd_q;
  assign io.IDEXRegWr    = regwr_q;
  assign io.IDEXMemRd    = memrd_q;
  assign io.IDEXMemWr    = memwr_q;
  assign io.IDEXMemToReg = memtoreg_q;
  assign io.IDEXRegDst   = regdst_q;
  assign io.IDEXALUSrc   = alusrc_q;
  assign io.IDEXALUOp    = aluop_q;
  assign io.IDEXBusA     = busa_q;
  assign io.IDEXBusB     = busb_q;
  assign io.IDEXImm      = imm_q;
  assign io.IDEXPCPlus4  = pc4_q;
  assign io.Stall        = stall;
  assign io.PCWr         = ~stall;
  assign io.IFIDWr       = ~stall;
  assign io.BubbleCnt    = cnt_q;
endmodule

// File: tb/tb_pipe_idex_stage.sv
// Bench for pipe_idex_stage: directed hazard/flush/saturation/reset scenarios, then
// randomized traffic, all against an instruction-level reference model.
module tb_pipe_idex_stage;
  localparam int DW = 32, ALUOP_W = 4, CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [4:0]  rs, rt, rd;
    logic        regwr, memrd, memwr;
    logic [1:0]  memtoreg, regdst;
    logic        alusrc;
    logic [3:0]  aluop;
    logic [31:0] busa, busb, imm, pc4;
  } idex_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pipe_idex_if #(.DW(DW), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();
  pipe_idex_stage #(.DW(DW), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .io(bus)
  );

  always #5 clk = ~clk;

  idex_t dut_o;
  assign dut_o = {bus.IDEXRs, bus.IDEXRt, bus.IDEXRd, bus.IDEXRegWr, bus.IDEXMemRd, bus.IDEXMemWr,
                  bus.IDEXMemToReg, bus.IDEXRegDst, bus.IDEXALUSrc, bus.IDEXALUOp,
                  bus.IDEXBusA, bus.IDEXBusB, bus.IDEXImm, bus.IDEXPCPlus4};

  // Reference: what EX currently holds, what ID currently presents, bubble count.
  idex_t in_v;
  logic  in_flush;
  idex_t m_ex;
  int    m_cnt;
  idex_t exp_q[$];
  int    exp_cnt_q[$];

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input idex_t v, input logic fl);
    in_v = v;
    in_flush = fl;
    bus.IFIDRs = v.rs; bus.IFIDRt = v.rt; bus.IFIDRd = v.rd;
    bus.ID_RegWr = v.regwr; bus.ID_MemRd = v.memrd; bus.ID_MemWr = v.memwr;
    bus.ID_MemToReg = v.memtoreg; bus.ID_RegDst = v.regdst; bus.ID_ALUSrc = v.alusrc;
    bus.ID_ALUOp = v.aluop; bus.ID_BusA = v.busa; bus.ID_BusB = v.busb;
    bus.ID_Imm = v.imm; bus.ID_PCPlus4 = v.pc4; bus.Flush = fl;
  endtask

  function automatic idex_t rand_in();
    idex_t v;
    v.rs = 5'($urandom_range(0, 7));
    v.rt = 5'($urandom_range(0, 7));
    v.rd = 5'($urandom_range(0, 31));
    v.regwr = 1'($urandom_range(0, 1));
    v.memrd = ($urandom_range(0, 2) == 0);
    v.memwr = 1'($urandom_range(0, 1));
    v.memtoreg = 2'($urandom_range(0, 3));
    v.regdst = 2'($urandom_range(0, 3));
    v.alusrc = 1'($urandom_range(0, 1));
    v.aluop = 4'($urandom_range(0, 15));
    v.busa = $urandom; v.busb = $urandom; v.imm = $urandom; v.pc4 = $urandom;
    return v;
  endfunction

  // One clock: check hazard outputs mid-cycle, predict the capture, check it after the edge.
  task automatic cycle();
    bit    load_use;
    idex_t nxt;
    @(negedge clk);
    load_use = m_ex.memrd && (m_ex.rt != 0) && (m_ex.rt == in_v.rs || m_ex.rt == in_v.rt);
    check("stall", 160'(bus.Stall), 160'(load_use));
    check("pcwr", 160'(bus.PCWr), 160'(!load_use));
    check("ifidwr", 160'(bus.IFIDWr), 160'(!load_use));
    if (reset) begin
      nxt = '0;
      exp_cnt_q.push_back(0);
    end else if (load_use || in_flush) begin
      nxt = '0;
      nxt.busa = in_v.busa; nxt.busb = in_v.busb; nxt.imm = in_v.imm; nxt.pc4 = in_v.pc4;
      exp_cnt_q.push_back(m_cnt < CNT_MAX ? m_cnt + 1 : CNT_MAX);
    end else begin
      nxt = in_v;
      exp_cnt_q.push_back(m_cnt);
    end
    exp_q.push_back(nxt);
    @(posedge clk);
    #1;
    m_ex = exp_q.pop_front();
    m_cnt = exp_cnt_q.pop_front();
    check("idex", 160'(dut_o), 160'(m_ex));
    check("bubble_cnt", 160'(bus.BubbleCnt), 160'(m_cnt));
  endtask

  idex_t v;

  initial begin
    m_ex = '0;
    m_cnt = 0;
    drive('0, 1'b0);
    reset = 1'b1;
    cycle();
    cycle();
    check("rst_idex", 160'(dut_o), 160'(0));
    check("rst_cnt", 160'(bus.BubbleCnt), 160'(0));
    reset = 1'b0;

    // Plain capture.
    v = '0; v.regwr = 1'b1; v.rs = 5'd3; v.busa = 32'h1234;
    drive(v, 1'b0);
    cycle();
    check("t1_regwr", 160'(bus.IDEXRegWr), 160'(1));
    check("t1_rs", 160'(bus.IDEXRs), 160'(3));
    check("t1_busa", 160'(bus.IDEXBusA), 160'h1234);

    // lw $5 then a reader of $5: one-cycle stall, then the held instruction loads.
    v = '0; v.memrd = 1'b1; v.rt = 5'd5; v.regwr = 1'b1;
    drive(v, 1'b0);
    cycle();
    v = '0; v.rs = 5'd5; v.regwr = 1'b1; v.busa = 32'hbeef;
    drive(v, 1'b0);
    #1;
    check("t2_stall", 160'(bus.Stall), 160'(1));
    check("t2_pcwr", 160'(bus.PCWr), 160'(0));
    cycle();
    check("t2_memrd", 160'(bus.IDEXMemRd), 160'(0));
    check("t2_rs_bubble", 160'(bus.IDEXRs), 160'(0));
    check("t2_cnt", 160'(bus.BubbleCnt), 160'(1));
    cycle();
    check("t2_rs_held", 160'(bus.IDEXRs), 160'(5));

    // lw $0 followed by a user of $0: never a hazard.
    v = '0; v.memrd = 1'b1; v.rt = 5'd0;
    drive(v, 1'b0);
    cycle();
    v = '0; v.rt = 5'd0; v.rs = 5'd0;
    drive(v, 1'b0);
    cycle();
    check("t3_cnt", 160'(bus.BubbleCnt), 160'(1));

    // Flush coincident with a load-use hazard: a single bubble.
    v = '0; v.memrd = 1'b1; v.rt = 5'd7;
    drive(v, 1'b0);
    cycle();
    v = '0; v.rs = 5'd7; v.regwr = 1'b1; v.aluop = 4'hA;
    drive(v, 1'b1);
    cycle();
    check("t4_cnt", 160'(bus.BubbleCnt), 160'(2));
    check("t4_ctrl", 160'({bus.IDEXRegWr, bus.IDEXALUOp}), 160'(0));

    // Saturation of the bubble counter.
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      drive(rand_in(), 1'b1);
      cycle();
    end
    check("t5_sat", 160'(bus.BubbleCnt), 160'(CNT_MAX));

    // Reset while stalled.
    v = '0; v.memrd = 1'b1; v.rt = 5'd9;
    drive(v, 1'b0);
    cycle();
    v = '0; v.rt = 5'd9;
    drive(v, 1'b0);
    reset = 1'b1;
    #1;
    check("t6_stall", 160'(bus.Stall), 160'(1));
    cycle();
    reset = 1'b0;
    check("t6_idex", 160'(dut_o), 160'(0));
    check("t6_cnt", 160'(bus.BubbleCnt), 160'(0));
    check("t6_pcwr", 160'(bus.PCWr), 160'(1));

    // Randomized traffic with occasional flushes and resets.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      drive(rand_in(), ($urandom_range(0, 9) == 0));
      cycle();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
